// File: rtl/isa_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// isa_pkg : bus-cycle state encoding and default ISA timing values
// Rev 1.0
// ------------------------------------------------------------------
package isa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_CMD   = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_NUM_DRQ   = 4;
    localparam int DEF_NUM_IRQ   = 4;
    localparam int DEF_SETUP_CYC = 2;
    localparam int DEF_CMD_CYC   = 4;
    localparam int DEF_HOLD_CYC  = 1;
    localparam int DEF_WAIT_MAX  = 64;
    localparam int DEF_RST_CYC   = 16;

    // DRQ release needs two synchroniser stages plus one cycle of margin
    localparam int DRQ_MASK_CYC  = 3;

endpackage
`default_nettype wire

// File: rtl/isa_sync.sv
`default_nettype none
// ------------------------------------------------------------------
// isa_sync : parametric-width two-flop synchroniser
// Rev 1.0
// ------------------------------------------------------------------
module isa_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        meta <= d;
        q    <= meta;
    end

endmodule
`default_nettype wire

// File: rtl/isa_dma_bridge.sv
`default_nettype none
// ------------------------------------------------------------------
// isa_dma_bridge : ISA bus master for PIO, DMA channel service and IRQ capture
// Rev 1.0
// ------------------------------------------------------------------
module isa_dma_bridge
    import isa_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int NUM_DRQ   = DEF_NUM_DRQ,
    parameter int NUM_IRQ   = DEF_NUM_IRQ,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int CMD_CYC   = DEF_CMD_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC,
    parameter int WAIT_MAX  = DEF_WAIT_MAX,
    parameter int RST_CYC   = DEF_RST_CYC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [DATA_W-1:0]  req_wdata,
    output logic               resp_valid,
    output logic [DATA_W-1:0]  resp_rdata,
    output logic               resp_err,
    input  logic [NUM_DRQ-1:0] dma_dir,
    input  logic [NUM_DRQ-1:0] dma_en,
    input  logic               dma_tx_valid,
    input  logic [DATA_W-1:0]  dma_tx_data,
    output logic               dma_tx_ready,
    output logic               dma_rx_valid,
    output logic [DATA_W-1:0]  dma_rx_data,
    output logic [2:0]         dma_chan,
    output logic [ADDR_W-1:0]  isa_a,
    output logic               isa_aen,
    input  logic [DATA_W-1:0]  isa_d_in,
    output logic [DATA_W-1:0]  isa_d_out,
    output logic               isa_d_oe,
    output logic               isa_ior_n,
    output logic               isa_iow_n,
    input  logic               isa_iochrdy,
    input  logic [NUM_DRQ-1:0] isa_drq,
    output logic [NUM_DRQ-1:0] isa_dack_n,
    input  logic [NUM_IRQ-1:0] isa_irq,
    input  logic [NUM_IRQ-1:0] irq_clear,
    output logic [NUM_IRQ-1:0] irq_pending,
    output logic               irq_any,
    output logic               isa_reset
);

    localparam int CNT_W = $clog2(SETUP_CYC + CMD_CYC + WAIT_MAX + HOLD_CYC + 1);
    localparam int RST_W = $clog2(RST_CYC + 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(CMD_CYC + WAIT_MAX - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [RST_W-1:0] RST_LOAD   = RST_W'(RST_CYC);
    localparam logic [1:0]       MASK_LOAD  = 2'(DRQ_MASK_CYC);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [RST_W-1:0]   rst_cnt;
    logic               is_dma;
    logic               is_write;
    logic               timed_out;
    logic [DATA_W-1:0]  rd_data;
    logic [1:0]         mask_cnt [NUM_DRQ];
    logic [NUM_DRQ-1:0] drq_s;
    logic [NUM_IRQ-1:0] irq_s;
    logic [NUM_IRQ-1:0] irq_prev;
    logic               rdy_s;

    logic [NUM_DRQ-1:0] eligible;
    logic [NUM_DRQ-1:0] grant_oh;
    logic [2:0]         grant_chan;
    logic               grant_dir;
    logic               grant_hit;
    logic               cmd_ok;
    logic               cmd_tmo;
    logic               hold_done;

    isa_sync #(.WIDTH(NUM_DRQ)) u_drq_sync (.clk(clk), .d(isa_drq),     .q(drq_s));
    isa_sync #(.WIDTH(NUM_IRQ)) u_irq_sync (.clk(clk), .d(isa_irq),     .q(irq_s));
    isa_sync #(.WIDTH(1))       u_rdy_sync (.clk(clk), .d(isa_iochrdy), .q(rdy_s));

    // Fixed priority: the lowest eligible channel index is granted
    always_comb begin
        eligible   = '0;
        grant_oh   = '0;
        grant_chan = 3'd0;
        grant_dir  = 1'b0;
        for (int i = 0; i < NUM_DRQ; i++) begin
            eligible[i] = drq_s[i] & dma_en[i] & (~dma_dir[i] | dma_tx_valid)
                        & (mask_cnt[i] == 2'd0);
        end
        for (int i = NUM_DRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                grant_oh    = '0;
                grant_oh[i] = 1'b1;
                grant_chan  = 3'(i);
                grant_dir   = dma_dir[i];
            end
        end
        grant_hit = (state == ST_IDLE) && !isa_reset && (|eligible);
    end

    assign req_ready = (state == ST_IDLE) && !isa_reset && !(|eligible);
    assign cmd_ok    = (cnt >= CMD_LAST) && rdy_s;
    assign cmd_tmo   = (cnt >= TMO_LAST);
    assign hold_done = (state == ST_HOLD) && (cnt == HOLD_LAST);
    assign irq_any   = |irq_pending;

    always_ff @(posedge clk) begin
        irq_prev <= irq_s;
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            rst_cnt      <= RST_LOAD;
            isa_reset    <= 1'b1;
            is_dma       <= 1'b0;
            is_write     <= 1'b0;
            timed_out    <= 1'b0;
            rd_data      <= '0;
            isa_a        <= '0;
            isa_aen      <= 1'b0;
            isa_d_out    <= '0;
            isa_d_oe     <= 1'b0;
            isa_ior_n    <= 1'b1;
            isa_iow_n    <= 1'b1;
            isa_dack_n   <= '1;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_err     <= 1'b0;
            dma_tx_ready <= 1'b0;
            dma_rx_valid <= 1'b0;
            dma_rx_data  <= '0;
            dma_chan     <= 3'd0;
            irq_pending  <= '0;
            for (int i = 0; i < NUM_DRQ; i++) mask_cnt[i] <= 2'd0;
        end else begin
            resp_valid   <= 1'b0;
            dma_tx_ready <= 1'b0;
            dma_rx_valid <= 1'b0;
            // A clear never wins against an edge arriving in the same cycle
            irq_pending  <= (irq_pending & ~irq_clear) | (irq_s & ~irq_prev);
            if (rst_cnt != '0) rst_cnt <= rst_cnt - RST_W'(1);
            isa_reset    <= (rst_cnt > RST_W'(1));
            for (int i = 0; i < NUM_DRQ; i++) begin
                if (hold_done && is_dma && (dma_chan == 3'(i)))
                    mask_cnt[i] <= MASK_LOAD;
                else if (mask_cnt[i] != 2'd0)
                    mask_cnt[i] <= mask_cnt[i] - 2'd1;
            end

            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (grant_hit) begin
                        state        <= ST_SETUP;
                        is_dma       <= 1'b1;
                        is_write     <= grant_dir;
                        dma_chan     <= grant_chan;
                        isa_aen      <= 1'b1;
                        isa_a        <= '0;
                        isa_dack_n   <= ~grant_oh;
                        isa_d_oe     <= grant_dir;
                        isa_d_out    <= grant_dir ? dma_tx_data : '0;
                        dma_tx_ready <= grant_dir;
                    end else if (req_valid && req_ready) begin
                        state     <= ST_SETUP;
                        is_dma    <= 1'b0;
                        is_write  <= req_write;
                        isa_aen   <= 1'b0;
                        isa_a     <= req_addr;
                        isa_d_oe  <= req_write;
                        isa_d_out <= req_write ? req_wdata : '0;
                    end
                end
                ST_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        state <= ST_CMD;
                        cnt   <= '0;
                        if (is_write) isa_iow_n <= 1'b0;
                        else          isa_ior_n <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_CMD: begin
                    if (cmd_ok || cmd_tmo) begin
                        state     <= ST_HOLD;
                        cnt       <= '0;
                        isa_ior_n <= 1'b1;
                        isa_iow_n <= 1'b1;
                        timed_out <= !cmd_ok;
                        rd_data   <= !cmd_ok ? {DATA_W{1'b1}} : (is_write ? '0 : isa_d_in);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (hold_done) begin
                        state      <= ST_IDLE;
                        cnt        <= '0;
                        isa_aen    <= 1'b0;
                        isa_a      <= '0;
                        isa_d_oe   <= 1'b0;
                        isa_d_out  <= '0;
                        isa_dack_n <= '1;
                        if (is_dma) begin
                            if (!is_write) begin
                                dma_rx_valid <= 1'b1;
                                dma_rx_data  <= rd_data;
                            end
                        end else begin
                            resp_valid <= 1'b1;
                            resp_rdata <= rd_data;
                            resp_err   <= timed_out;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_isa_dma_bridge.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_isa_dma_bridge : directed, self-checking bench for isa_dma_bridge
// Rev 1.0
// ------------------------------------------------------------------
`timescale 1ns/1ps
module tb_isa_dma_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [15:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [15:0] resp_rdata;
    logic [3:0]  dma_dir, dma_en;
    logic        dma_tx_valid, dma_tx_ready, dma_rx_valid;
    logic [15:0] dma_tx_data, dma_rx_data;
    logic [2:0]  dma_chan;
    logic [15:0] isa_a, isa_d_in, isa_d_out;
    logic        isa_aen, isa_d_oe, isa_ior_n, isa_iow_n, isa_iochrdy;
    logic [3:0]  isa_drq, isa_dack_n, isa_irq, irq_clear, irq_pending;
    logic        irq_any, isa_reset;

    always #5 clk = ~clk;

    isa_dma_bridge #(
        .DATA_W(16), .ADDR_W(16), .NUM_DRQ(4), .NUM_IRQ(4), .SETUP_CYC(2),
        .CMD_CYC(4), .HOLD_CYC(1), .WAIT_MAX(64), .RST_CYC(16)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .dma_dir(dma_dir), .dma_en(dma_en), .dma_tx_valid(dma_tx_valid),
        .dma_tx_data(dma_tx_data), .dma_tx_ready(dma_tx_ready),
        .dma_rx_valid(dma_rx_valid), .dma_rx_data(dma_rx_data), .dma_chan(dma_chan),
        .isa_a(isa_a), .isa_aen(isa_aen), .isa_d_in(isa_d_in), .isa_d_out(isa_d_out),
        .isa_d_oe(isa_d_oe), .isa_ior_n(isa_ior_n), .isa_iow_n(isa_iow_n),
        .isa_iochrdy(isa_iochrdy), .isa_drq(isa_drq), .isa_dack_n(isa_dack_n),
        .isa_irq(isa_irq), .irq_clear(irq_clear), .irq_pending(irq_pending),
        .irq_any(irq_any), .isa_reset(isa_reset)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 is the cycle whose closing edge accepts the request.
    // lo_first..lo_last are the edge numbers at which iochrdy is sampled low.
    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] din;
        int          samp;
        int          lo_first;
        int          lo_last;
        int          s_first;
        int          s_last;
        int          resp_cyc;
        logic        err;
        logic [15:0] rdata;
    } pio_vec_t;

    pio_vec_t vec [5];

    task automatic run_pio(input pio_vec_t v, input int idx);
        int   s_first, s_last, other_lo, doe_first, doe_last, resp_c, n_resp;
        int   aen_hi, addr_bad, dout_bad, last;
        logic strobe, other, err_seen;
        logic [15:0] rd_seen;
        s_first = -1; s_last = -1; other_lo = 0; doe_first = -1; doe_last = -1;
        resp_c = -1; n_resp = 0; aen_hi = 0; addr_bad = 0; dout_bad = 0;
        err_seen = 1'b0; rd_seen = '0;
        last = v.resp_cyc + 2;
        chk($sformatf("v%0d req_ready", idx), {31'd0, req_ready}, 32'd1);
        req_valid   = 1'b1;
        req_write   = v.wr;
        req_addr    = v.addr;
        req_wdata   = v.wdata;
        isa_iochrdy = !(1 >= v.lo_first && 1 <= v.lo_last);
        isa_d_in    = 16'hD000;
        for (int c = 1; c <= last; c++) begin
            step();
            if (c == 1) req_valid = 1'b0;
            isa_iochrdy = !(c + 1 >= v.lo_first && c + 1 <= v.lo_last);
            isa_d_in    = (c == v.samp) ? v.din : (16'hD000 ^ 16'(c));
            strobe = v.wr ? isa_iow_n : isa_ior_n;
            other  = v.wr ? isa_ior_n : isa_iow_n;
            if (!strobe) begin
                if (s_first < 0) s_first = c;
                s_last = c;
                if (isa_a != v.addr) addr_bad++;
            end
            if (!other) other_lo++;
            if (isa_d_oe) begin
                if (doe_first < 0) doe_first = c;
                doe_last = c;
                if (isa_d_out != v.wdata) dout_bad++;
            end
            if (isa_aen) aen_hi++;
            if (resp_valid) begin
                n_resp++;
                resp_c   = c;
                err_seen = resp_err;
                rd_seen  = resp_rdata;
            end
        end
        isa_iochrdy = 1'b1;
        chk($sformatf("v%0d strobe_first", idx), s_first, v.s_first);
        chk($sformatf("v%0d strobe_last", idx), s_last, v.s_last);
        chk($sformatf("v%0d other_strobe_low", idx), other_lo, 0);
        chk($sformatf("v%0d isa_a", idx), addr_bad, 0);
        chk($sformatf("v%0d aen_cycles", idx), aen_hi, 0);
        chk($sformatf("v%0d d_oe_first", idx), doe_first, v.wr ? 1 : -1);
        chk($sformatf("v%0d d_oe_last", idx), doe_last, v.wr ? v.resp_cyc - 1 : -1);
        chk($sformatf("v%0d d_out", idx), dout_bad, 0);
        chk($sformatf("v%0d resp_cycle", idx), resp_c, v.resp_cyc);
        chk($sformatf("v%0d resp_count", idx), n_resp, 1);
        chk($sformatf("v%0d resp_err", idx), {31'd0, err_seen}, {31'd0, v.err});
        if (!v.wr || v.err)
            chk($sformatf("v%0d resp_rdata", idx), {16'd0, rd_seen}, {16'd0, v.rdata});
        repeat (3) step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, rr_bad, resp_seen, aen_hi, aen_bad, a_bad, ev_n, n_tx, tx_chan, tx_dack_ok;
        int iow_cnt, ior_bad, dbad, rx_n, blocked;
        int ev_ch [4];
        logic [15:0] ev_d [4];
        logic acc;

        vec[0] = '{1'b1, 16'h0220, 16'h00D1, 16'h0000, -1, -5, -5,  3,  6,  8, 1'b0, 16'h0000};
        vec[1] = '{1'b0, 16'h0388, 16'h0000, 16'h5A3C,  9,  5,  7,  3,  9, 11, 1'b0, 16'h5A3C};
        vec[2] = '{1'b0, 16'h0300, 16'h0000, 16'h0000, -1,  0, 9999, 3, 70, 72, 1'b1, 16'hFFFF};
        vec[3] = '{1'b1, 16'h03F8, 16'h1234, 16'h0000, -1,  4,  8,  3, 10, 12, 1'b0, 16'h0000};
        vec[4] = '{1'b0, 16'h0201, 16'h0000, 16'h00A5,  6,  2,  4,  3,  6,  8, 1'b0, 16'h00A5};

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        dma_dir = '0; dma_en = '0; dma_tx_valid = 1'b0; dma_tx_data = '0;
        isa_d_in = '0; isa_iochrdy = 1'b1; isa_drq = '0; isa_irq = '0; irq_clear = '0;
        repeat (3) step();

        chk("rst ior_n", {31'd0, isa_ior_n}, 32'd1);
        chk("rst iow_n", {31'd0, isa_iow_n}, 32'd1);
        chk("rst dack_n", {28'd0, isa_dack_n}, 32'hF);
        chk("rst d_oe", {31'd0, isa_d_oe}, 32'd0);
        chk("rst aen", {31'd0, isa_aen}, 32'd0);
        chk("rst isa_a", {16'd0, isa_a}, 32'd0);
        chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst irq_pending", {28'd0, irq_pending}, 32'd0);
        chk("rst isa_reset", {31'd0, isa_reset}, 32'd1);
        chk("rst req_ready", {31'd0, req_ready}, 32'd0);

        reset = 1'b0;
        n = 0; rr_bad = 0;
        for (int k = 0; k < 100; k++) begin
            if (!isa_reset) break;
            n++;
            if (req_ready) rr_bad++;
            step();
        end
        chk("isa_reset stretch", n, 16);
        chk("req_ready during isa_reset", rr_bad, 0);
        step();

        for (int i = 0; i < 5; i++) run_pio(vec[i], i);

        // Two DMA read channels requested together, PIO queued behind them
        dma_en = 4'b1010; dma_dir = 4'b0000; isa_drq = 4'b1010;
        ev_n = 0; aen_hi = 0; aen_bad = 0; a_bad = 0;
        for (int c = 0; c < 300 && ev_n < 3; c++) begin
            if (c == 2) begin
                req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0100;
            end
            acc = req_valid && req_ready;
            step();
            if (acc) req_valid = 1'b0;
            for (int i = 0; i < 4; i++) if (!isa_dack_n[i]) isa_drq[i] = 1'b0;
            isa_d_in = !isa_dack_n[1] ? 16'h1111 : (!isa_dack_n[3] ? 16'h3333 : 16'hABCD);
            if (isa_aen) aen_hi++;
            if (isa_aen != (isa_dack_n != 4'hF)) aen_bad++;
            if (isa_aen && isa_a != 16'h0000) a_bad++;
            if (dma_rx_valid && ev_n < 4) begin
                ev_ch[ev_n] = int'(dma_chan); ev_d[ev_n] = dma_rx_data; ev_n++;
            end
            if (resp_valid && ev_n < 4) begin
                ev_ch[ev_n] = 8; ev_d[ev_n] = resp_rdata; ev_n++;
            end
        end
        chk("dma event count", ev_n, 3);
        if (ev_n >= 3) begin
            chk("dma first chan", ev_ch[0], 1);
            chk("dma first data", {16'd0, ev_d[0]}, 32'h1111);
            chk("dma second chan", ev_ch[1], 3);
            chk("dma second data", {16'd0, ev_d[1]}, 32'h3333);
            chk("pio after dma", ev_ch[2], 8);
            chk("pio after dma data", {16'd0, ev_d[2]}, 32'hABCD);
        end
        chk("dma aen cycles", aen_hi, 14);
        chk("aen tracks dack", aen_bad, 0);
        chk("dma isa_a zero", a_bad, 0);
        dma_en = '0; isa_drq = '0;
        repeat (4) step();

        // Host-to-device channel 0: blocked until tx data is offered
        dma_en = 4'b0001; dma_dir = 4'b0001; isa_drq = 4'b0001;
        dma_tx_valid = 1'b0; dma_tx_data = 16'hBEEF;
        blocked = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (isa_dack_n != 4'hF) blocked++;
        end
        chk("tx blocked without tx_valid", blocked, 0);
        dma_tx_valid = 1'b1;
        n_tx = 0; tx_chan = -1; tx_dack_ok = 0; iow_cnt = 0; ior_bad = 0; dbad = 0; rx_n = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (dma_tx_ready) begin
                n_tx++; tx_chan = int'(dma_chan);
                if (!isa_dack_n[0]) tx_dack_ok = 1;
                dma_tx_valid = 1'b0;
            end
            if (!isa_dack_n[0]) isa_drq[0] = 1'b0;
            if (!isa_iow_n) begin
                iow_cnt++;
                if (isa_d_out != 16'hBEEF || !isa_d_oe) dbad++;
            end
            if (!isa_ior_n) ior_bad++;
            if (dma_rx_valid) rx_n++;
        end
        chk("tx_ready pulses", n_tx, 1);
        chk("tx_ready chan", tx_chan, 0);
        chk("tx_ready with dack", tx_dack_ok, 1);
        chk("tx iow cycles", iow_cnt, 4);
        chk("tx d_out", dbad, 0);
        chk("tx no ior", ior_bad, 0);
        chk("tx no rx_valid", rx_n, 0);
        dma_en = '0; dma_dir = '0; isa_drq = '0;
        repeat (4) step();

        // IRQ capture, clear, and edge-beats-clear
        isa_irq[2] = 1'b1;
        repeat (3) step();
        chk("irq set", {28'd0, irq_pending}, 32'h4);
        chk("irq_any set", {31'd0, irq_any}, 32'd1);
        irq_clear[2] = 1'b1;
        step();
        irq_clear[2] = 1'b0;
        chk("irq cleared", {28'd0, irq_pending}, 32'h0);
        chk("irq_any cleared", {31'd0, irq_any}, 32'd0);
        repeat (3) step();
        chk("irq level no retrigger", {28'd0, irq_pending}, 32'h0);
        isa_irq[2] = 1'b0;
        repeat (4) step();
        isa_irq[2] = 1'b1;
        repeat (2) step();
        irq_clear[2] = 1'b1;
        chk("irq before edge", {28'd0, irq_pending}, 32'h0);
        step();
        irq_clear[2] = 1'b0;
        chk("irq edge beats clear", {28'd0, irq_pending}, 32'h4);
        irq_clear = 4'hF;
        step();
        irq_clear = '0;
        isa_irq = '0;
        repeat (3) step();

        // Reset landing in the middle of a PIO write strobe
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0300; req_wdata = 16'h7777;
        step();
        req_valid = 1'b0;
        repeat (3) step();
        chk("pre-reset iow_n low", {31'd0, isa_iow_n}, 32'd0);
        reset = 1'b1;
        step();
        chk("mid rst iow_n", {31'd0, isa_iow_n}, 32'd1);
        chk("mid rst ior_n", {31'd0, isa_ior_n}, 32'd1);
        chk("mid rst dack_n", {28'd0, isa_dack_n}, 32'hF);
        chk("mid rst d_oe", {31'd0, isa_d_oe}, 32'd0);
        reset = 1'b0;
        n = 0; rr_bad = 0; resp_seen = 0;
        for (int k = 0; k < 100; k++) begin
            if (!isa_reset) break;
            n++;
            if (req_ready) rr_bad++;
            if (resp_valid) resp_seen++;
            step();
        end
        chk("mid rst isa_reset stretch", n, 16);
        chk("mid rst req_ready held", rr_bad, 0);
        for (int k = 0; k < 10; k++) begin
            if (resp_valid) resp_seen++;
            step();
        end
        chk("mid rst no resp", resp_seen, 0);
        chk("post rst req_ready", {31'd0, req_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/isa_dma_bridge.md
ISA_DMA_BRIDGE -- requirements
Module: isa_dma_bridge

Interface
REQ-001 SHALL have parameters: DATA_W 16 (ISA data width, 8 or 16); ADDR_W 16 (I/O address width); NUM_DRQ 4 (DMA channels, 1..8); NUM_IRQ 4 (IRQ lines, 1..8); SETUP_CYC 2 (address-to-strobe cycles, >=1); CMD_CYC 4 (minimum strobe-low cycles, >=1); HOLD_CYC 1 (strobe-release-to-idle cycles, >=1); WAIT_MAX 64 (IOCHRDY extension limit); RST_CYC 16 (ISA reset stretch).
REQ-002 SHALL have ports: clk in 1 (system clock); reset in 1 (synchronous, active-high); req_valid in 1; req_ready out 1; req_write in 1; req_addr in ADDR_W; req_wdata in DATA_W; resp_valid out 1; resp_rdata out DATA_W; resp_err out 1.
REQ-003 SHALL have DMA ports: dma_dir in NUM_DRQ (1 = host-to-device); dma_en in NUM_DRQ; dma_tx_valid in 1; dma_tx_data in DATA_W; dma_tx_ready out 1; dma_rx_valid out 1; dma_rx_data out DATA_W; dma_chan out 3.
REQ-004 SHALL have ISA ports: isa_a out ADDR_W; isa_aen out 1; isa_d_in in DATA_W; isa_d_out out DATA_W; isa_d_oe out 1; isa_ior_n out 1; isa_iow_n out 1; isa_iochrdy in 1; isa_drq in NUM_DRQ; isa_dack_n out NUM_DRQ; isa_irq in NUM_IRQ; irq_clear in NUM_IRQ; irq_pending out NUM_IRQ; irq_any out 1; isa_reset out 1.

Function
REQ-005 SHALL run FSM IDLE -> SETUP (SETUP_CYC) -> CMD (>= CMD_CYC) -> HOLD (HOLD_CYC) -> IDLE; IDLE lasts at least one cycle.
REQ-006 SHALL assert req_ready only in IDLE with no DMA grant; accept on req_valid & req_ready (cycle 0).
REQ-007 PIO: isa_a = req_addr, isa_aen = 0 from SETUP through HOLD; isa_iow_n (write) or isa_ior_n (read) low only in CMD.
REQ-008 Writes: isa_d_oe = 1 and isa_d_out = req_wdata from SETUP through HOLD; reads: isa_d_oe = 0.
REQ-009 CMD SHALL end after CMD_CYC cycles only when synchronised isa_iochrdy is high; else extend up to WAIT_MAX further cycles.
REQ-010 Read data SHALL be sampled from isa_d_in in the final CMD cycle.
REQ-011 On WAIT_MAX expiry: release strobe, resp_err = 1, resp_rdata = all ones; otherwise resp_err = 0.
REQ-012 resp_valid SHALL pulse one cycle in the first IDLE cycle after HOLD, for reads and writes; unloaded PIO latency = SETUP_CYC+CMD_CYC+HOLD_CYC+1.
REQ-013 DRQs SHALL pass a 2-flop synchroniser; eligible channel = synced DRQ & dma_en & (dma_dir=0 or dma_tx_valid) & not masked.
REQ-014 Arbitration in IDLE: DMA over PIO; lowest channel index wins; no preemption of an in-flight cycle.
REQ-015 DMA cycle: isa_aen = 1, isa_a = 0, isa_dack_n[i] low SETUP through HOLD; dir=1 uses isa_iow_n with dma_tx_data, dma_tx_ready pulsed at grant; dir=0 uses isa_ior_n.
REQ-016 dir=0 SHALL pulse dma_rx_valid with sampled data in first IDLE cycle; no backpressure (consumer always accepts); dma_chan = serviced channel on tx_ready/rx_valid.
REQ-017 Serviced channel SHALL be masked 3 cycles after HOLD to absorb synchroniser delay of DRQ release.
REQ-018 IRQs SHALL be 2-flop synchronised; rising edge sets irq_pending[k]; irq_clear[k] clears; simultaneous edge and clear leaves bit set; irq_any = |irq_pending.
REQ-019 DATA_W = 8 SHALL leave upper behaviour absent (ports DATA_W wide only).

Reset
REQ-020 On reset: FSM IDLE, isa_ior_n = isa_iow_n = 1, isa_dack_n all 1, isa_d_oe = 0, isa_aen = 0, isa_a = 0, resp_valid = dma_tx_ready = dma_rx_valid = 0, irq_pending = 0, masks cleared; effective on next edge even mid-cycle; in-flight response discarded.
REQ-021 isa_reset SHALL be 1 during reset and RST_CYC cycles after release; req_ready and DMA grants SHALL stay 0 while isa_reset = 1.

Structure
REQ-022 Package isa_pkg SHALL hold FSM state enum and default timing constants.
REQ-023 Sub-module isa_sync (parametric-width 2-flop synchroniser) SHALL serve DRQ, IRQ and IOCHRDY.

Verification (defaults)
REQ-024 PIO write 0x0220/0x00D1, iochrdy=1 -> iow_n low cycles 3-6, d_oe 1-7, resp_valid cycle 8, resp_err 0.
REQ-025 PIO read 0x0388, iochrdy low cycles 5-7 -> ior_n low 3-9, resp_rdata = isa_d_in at cycle 9, resp_valid cycle 11.
REQ-026 iochrdy held low -> strobe released after 4+64 cycles, resp_err 1, resp_rdata 0xFFFF.
REQ-027 DRQ1 and DRQ3 raised together with req_valid pending, dir=0 -> channel 1 served first, then 3, then PIO; aen 1 only on DMA cycles.
REQ-028 Reset asserted during CMD -> strobes/dack high next edge, isa_reset high 16 cycles post-release, no resp_valid.
